// File: rtl/tile_result_writer.sv
// tile_result_writer: buffers per-pixel solver results in a small FIFO and drains
// each one as a single 16-bit memory-mapped write, honouring waitrequest stalls.
module tile_result_writer #(
    parameter int          FIFO_DEPTH_BITS = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_addr,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] avm_address,
    output logic [15:0] avm_writedata,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    input  logic        count_clear,
    output logic [31:0] pixel_count,
    output logic        busy
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0]   FULL_COUNT = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    localparam logic [FIFO_DEPTH_BITS:0]   OCC_ONE    = 1;
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE    = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    logic [47:0]                fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   occupancy;
    logic [0:0]                 state;

    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        accept;
    logic [47:0] head;
    logic [31:0] head_byte_addr;

    assign fifo_empty     = (occupancy == '0);
    assign in_ready       = (occupancy != FULL_COUNT);
    assign push           = in_valid && in_ready;
    assign avm_write      = (state == ST_WRITE);
    assign accept         = avm_write && !avm_waitrequest;
    assign pop            = !fifo_empty && (!avm_write || accept);
    assign head           = fifo_mem[rd_ptr];
    assign head_byte_addr = BASE_ADDR + (head[47:16] << 1);
    assign busy           = !fifo_empty || avm_write;

    // Storage is never reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // A pop always reloads the holding register, which covers both the IDLE start
    // and the back-to-back reload on an accept edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else if (pop) begin
            state         <= ST_WRITE;
            avm_address   <= head_byte_addr;
            avm_writedata <= head[15:0];
        end else if (accept) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_count <= '0;
        end else if (count_clear) begin
            pixel_count <= '0;
        end else if (accept) begin
            pixel_count <= pixel_count + 32'd1;
        end
    end

endmodule
